program_loader: RTL and testbench

Byte-stream program loader sitting directly upstream of the CPU. It consumes a framed byte stream from the serial receiver and drives the CPU's `download_program`, `instruction_index` and `program_in` inputs, writing 16-bit instructions into the instruction cache. `download_program` freezes the pipeline for the whole load and releases it when the load completes.

---
 rtl/loader_pkg.sv | 16 +
 rtl/loader_checksum.sv | 34 +++
 rtl/program_loader.sv | 155 +++++++++++++++
 tb/tb_program_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        DATA_LO,
        DATA_HI,
        CHECK,
        DONE,
        ERR
    } loader_state_t;

    localparam int LOADER_COUNT_W = 16;

endpackage

// File: rtl/loader_checksum.sv
// XOR accumulator over accepted frame bytes; clr restarts the sum (with en, from the current byte).
module loader_checksum
    import loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] sum
);

    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = en ? data : 8'h00;
        end else if (en) begin
            sum_d = sum_q ^ data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader driving the CPU instruction-cache download port.
// Optional trailing XOR checksum: define PROGRAM_LOADER_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | waiting for count low byte, CPU released
// CNT_HI  | waiting for count high byte
// DATA_LO | waiting for instruction low byte
// DATA_HI | waiting for instruction high byte, writes the word pair
// CHECK   | waiting for checksum byte
// DONE    | one-cycle completion pulse, last word still presented
// ERR     | checksum mismatch, CPU held until reset
module program_loader
    import loader_pkg::*;
#(
    parameter int MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        download_program,
    output logic [31:0] instruction_index,
    output logic [15:0] program_in,
    output logic        load_done,
    output logic        overflow
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,
    output logic        load_error
`endif
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam loader_state_t TAIL = CHECK;
`else
    localparam loader_state_t TAIL = DONE;
`endif

    loader_state_t state_q, state_d;
    logic                      ready_q, ready_d;
    logic [7:0]                lo_q, lo_d;
    logic [LOADER_COUNT_W-1:0] cnt_q, cnt_d;
    logic [LOADER_COUNT_W-1:0] w_q, w_d;
    logic [LOADER_COUNT_W-1:0] idx_q, idx_d;
    logic [15:0]               pin_q, pin_d;
    logic                      ovf_q, ovf_d;
    logic                      accept;

    assign accept = rx_valid & ready_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] sum;

    loader_checksum u_checksum (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     ((state_q == IDLE) || (state_q == DONE)),
        .en      (accept),
        .data    (rx_data),
        .sum     (sum)
    );
`endif

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        idx_d   = idx_q;
        pin_d   = pin_q;
        ovf_d   = ovf_q;
        case (state_q)
            // A byte taken during DONE is the next frame's count low byte.
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    lo_d    = rx_data;
                    w_d     = '0;
                    state_d = CNT_HI;
                end
            end
            CNT_HI: begin
                if (accept) begin
                    cnt_d   = {rx_data, lo_q};
                    state_d = (cnt_d == '0) ? TAIL : DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    lo_d    = rx_data;
                    state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept) begin
                    if (32'(w_q) < 32'(MAX_WORDS)) begin
                        pin_d = {rx_data, lo_q};
                        idx_d = w_q;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    w_d     = w_q + 1'b1;
                    state_d = (w_d == cnt_q) ? TAIL : DATA_LO;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    state_d = (rx_data == sum) ? DONE : ERR;
                end
            end
            ERR: begin
                state_d = ERR;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d != ERR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            lo_q    <= '0;
            cnt_q   <= '0;
            w_q     <= '0;
            idx_q   <= '0;
            pin_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            idx_q   <= idx_d;
            pin_q   <= pin_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rx_ready          = ready_q;
    assign download_program  = (state_q != IDLE);
    assign load_done         = (state_q == DONE);
    assign overflow          = ovf_q;
    assign instruction_index = {16'h0000, idx_q};
    assign program_in        = pin_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign load_error        = (state_q == ERR);
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; follows PROGRAM_LOADER_CHECKSUM_EN for frame tails.
`timescale 1ns/1ps
module tb_program_loader;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        sel;

    logic        rdy0, dl0, done0, ovf0;
    logic [31:0] idx0;
    logic [15:0] pin0;
    logic        rdy1, dl1, done1, ovf1;
    logic [31:0] idx1;
    logic [15:0] pin1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic        err0, err1;
`endif

    always #5 clk = ~clk;

    program_loader u_dut0 (
        .clk               (clk),
        .reset_n           (reset_n),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid & ~sel),
        .rx_ready          (rdy0),
        .download_program  (dl0),
        .instruction_index (idx0),
        .program_in        (pin0),
        .load_done         (done0),
        .overflow          (ovf0)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ,
        .load_error        (err0)
`endif
    );

    program_loader #(.MAX_WORDS(2)) u_dut1 (
        .clk               (clk),
        .reset_n           (reset_n),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid & sel),
        .rx_ready          (rdy1),
        .download_program  (dl1),
        .instruction_index (idx1),
        .program_in        (pin1),
        .load_done         (done1),
        .overflow          (ovf1)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ,
        .load_error        (err1)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    int dl_cycles = 0;
    int done_cnt  = 0;
    logic [15:0] cache [0:15];
    logic [7:0]  frame_q [$];

    // Cache model: the word presented while download_program is high is written at the next edge.
    always @(negedge clk) begin
        if (dl0) begin
            dl_cycles = dl_cycles + 1;
            if (idx0 < 32'd16) cache[idx0[3:0]] = pin0;
        end
        if (done0) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!(sel ? rdy1 : rdy0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame();
        logic [7:0] x = 8'h00;
        foreach (frame_q[i]) begin
            send_byte(frame_q[i]);
            x = x ^ frame_q[i];
        end
        if (CS != 0) send_byte(x);
        rx_valid = 1'b0;
    endtask

    logic [7:0]  gap_b   [6] = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    logic [15:0] gap_pin [6] = '{16'h5678, 16'h5678, 16'h5678, 16'h1234, 16'h1234, 16'h5678};
    logic [31:0] gap_idx [6] = '{32'd1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd1};

    initial begin
        int dl_s, dn_s;
        logic [7:0] x;
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        sel      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", {31'd0, rdy0}, 32'd0);
        chk("rst_dl", {31'd0, dl0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_ovf", {31'd0, ovf0}, 32'd0);
        chk("rst_idx", idx0, 32'd0);
        chk("rst_pin", {16'd0, pin0}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", {31'd0, rdy0}, 32'd1);
        chk("idle_dl", {31'd0, dl0}, 32'd0);

        // back-to-back two-word load
        dl_s = dl_cycles; dn_s = done_cnt;
        frame_q = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
        send_frame();
        repeat (4) @(negedge clk);
        chk("b2b_cache0", {16'd0, cache[0]}, 32'h1234);
        chk("b2b_cache1", {16'd0, cache[1]}, 32'h5678);
        chk("b2b_dl_cycles", dl_cycles - dl_s, 6 + CS);
        chk("b2b_done_pulses", done_cnt - dn_s, 1);
        chk("b2b_dl_low", {31'd0, dl0}, 32'd0);
        chk("b2b_idx", idx0, 32'd1);

        // same frame with 3-cycle gaps
        dl_s = dl_cycles; dn_s = done_cnt;
        x = 8'h00;
        for (int i = 0; i < 6; i++) begin
            send_byte(gap_b[i]);
            x = x ^ gap_b[i];
            rx_valid = 1'b0;
            for (int g = 0; g < 3; g++) begin
                @(negedge clk);
                chk("gap_pin", {16'd0, pin0}, {16'd0, gap_pin[i]});
                chk("gap_idx", idx0, gap_idx[i]);
            end
        end
        if (CS != 0) begin
            chk("gap_xor", {24'd0, x}, 32'h0A);
            send_byte(x);
            rx_valid = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("gap_cache0", {16'd0, cache[0]}, 32'h1234);
        chk("gap_cache1", {16'd0, cache[1]}, 32'h5678);
        chk("gap_done_pulses", done_cnt - dn_s, 1);

        // empty frame
        dl_s = dl_cycles; dn_s = done_cnt;
        frame_q = {8'h00, 8'h00};
        send_frame();
        repeat (4) @(negedge clk);
        chk("zero_dl_cycles", dl_cycles - dl_s, 2 + CS);
        chk("zero_done_pulses", done_cnt - dn_s, 1);
        chk("zero_idx", idx0, 32'd1);
        chk("zero_pin", {16'd0, pin0}, 32'h5678);

        // overflow on the MAX_WORDS=2 instance
        sel = 1'b1;
        frame_q = {8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
        send_frame();
        repeat (4) @(negedge clk);
        chk("ovf_flag", {31'd0, ovf1}, 32'd1);
        chk("ovf_idx", idx1, 32'd1);
        chk("ovf_pin", {16'd0, pin1}, 32'h0002);
        chk("ovf_dl_low", {31'd0, dl1}, 32'd0);
        chk("no_ovf_dut0", {31'd0, ovf0}, 32'd0);
        sel = 1'b0;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        dl_s = dl_cycles; dn_s = done_cnt;
        frame_q = {8'h01, 8'h00, 8'hAA};
        foreach (frame_q[i]) send_byte(frame_q[i]);
        send_byte(8'h55);
        send_byte(8'hFE);
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("cs_ok_done", done_cnt - dn_s, 1);
        chk("cs_ok_cache0", {16'd0, cache[0]}, 32'h55AA);
        chk("cs_ok_err", {31'd0, err0}, 32'd0);

        dn_s = done_cnt;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'h55);
        send_byte(8'hFF);
        rx_data = 8'h00;
        repeat (6) @(negedge clk);
        rx_valid = 1'b0;
        chk("cs_bad_err", {31'd0, err0}, 32'd1);
        chk("cs_bad_dl_held", {31'd0, dl0}, 32'd1);
        chk("cs_bad_ready", {31'd0, rdy0}, 32'd0);
        chk("cs_bad_no_done", done_cnt - dn_s, 0);
        reset_n = 1'b0;
        #1;
        chk("cs_rst_err", {31'd0, err0}, 32'd0);
        chk("cs_rst_dl", {31'd0, dl0}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
`endif

        // reset in the middle of a load
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("mid_pin", {16'd0, pin0}, 32'h2211);
        chk("mid_dl", {31'd0, dl0}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_dl", {31'd0, dl0}, 32'd0);
        chk("midrst_idx", idx0, 32'd0);
        chk("midrst_pin", {16'd0, pin0}, 32'd0);
        chk("midrst_ovf1", {31'd0, ovf1}, 32'd0);
        chk("midrst_ready", {31'd0, rdy0}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
